// File: rtl/cache_controller.sv
// Sequencing controller for a direct-mapped, write-through, no-write-allocate cache.
// Owns the tag/data RAM strobes, the per-line valid bits and the main-memory handshake.
module cache_controller #(
    parameter int index      = 3,
    parameter int memorybits = 5,
    parameter int databits   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [memorybits-1:0]       cpu_addr,
    input  logic [databits-1:0]         cpu_wdata,
    output logic [databits-1:0]         cpu_rdata,
    output logic                        cpu_ready,
    output logic [index-1:0]            tag_index,
    output logic [memorybits-index-1:0] tag_wdata,
    input  logic [memorybits-index-1:0] tag_rdata,
    output logic                        tag_write,
    output logic                        tag_read,
    output logic [index-1:0]            data_index,
    output logic [databits-1:0]         data_wdata,
    input  logic [databits-1:0]         data_rdata,
    output logic                        data_write,
    output logic                        data_read,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [memorybits-1:0]       mem_addr,
    output logic [databits-1:0]         mem_wdata,
    input  logic [databits-1:0]         mem_rdata,
    input  logic                        mem_ack,
    output logic [15:0]                 hit_count,
    output logic [15:0]                 miss_count,
    output logic [2:0]                  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_COMPARE   = 3'd2,
        S_MEM_READ  = 3'd3,
        S_FILL      = 3'd4,
        S_MEM_WRITE = 3'd5
    } state_t;

    state_t                    state_q;
    logic [2**index-1:0]       valid_q;
    logic                      we_q;
    logic [memorybits-1:0]     addr_q;
    logic [databits-1:0]       wdata_q;
    logic [databits-1:0]       fill_q;
    logic [databits-1:0]       cpu_rdata_q;
    logic                      cpu_ready_q;
    logic [15:0]               hit_q;
    logic [15:0]               miss_q;

    logic [index-1:0]            line_idx;
    logic [memorybits-index-1:0] line_tag;
    logic                        hit;

    assign line_idx = addr_q[index-1:0];
    assign line_tag = addr_q[memorybits-1:index];
    // tag_rdata is only meaningful in COMPARE, one cycle after the LOOKUP read strobe.
    assign hit      = valid_q[line_idx] && (tag_rdata == line_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            fill_q      <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: state_q <= S_COMPARE;
                S_COMPARE: begin
                    if (hit) begin
                        hit_q <= hit_q + 16'd1;
                        if (we_q) begin
                            state_q <= S_MEM_WRITE;
                        end else begin
                            cpu_rdata_q <= data_rdata;
                            cpu_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end else begin
                        miss_q  <= miss_q + 16'd1;
                        state_q <= we_q ? S_MEM_WRITE : S_MEM_READ;
                    end
                end
                S_MEM_READ: begin
                    if (mem_ack) begin
                        fill_q  <= mem_rdata;
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    valid_q[line_idx] <= 1'b1;
                    cpu_rdata_q       <= fill_q;
                    cpu_ready_q       <= 1'b1;
                    state_q           <= S_IDLE;
                end
                S_MEM_WRITE: begin
                    if (mem_ack) begin
                        cpu_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Memory handshake: mem_req stays high from entry into MEM_READ/MEM_WRITE until the
    // edge that samples the one-cycle mem_ack; address/data are stable for the whole request.
    assign mem_req    = (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign mem_we     = (state_q == S_MEM_WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    assign tag_index  = line_idx;
    assign tag_wdata  = line_tag;
    assign tag_read   = (state_q == S_LOOKUP);
    assign tag_write  = (state_q == S_FILL);

    assign data_index = line_idx;
    assign data_read  = (state_q == S_LOOKUP);
    assign data_write = (state_q == S_FILL) || ((state_q == S_COMPARE) && we_q && hit);
    assign data_wdata = (state_q == S_FILL) ? fill_q : wdata_q;

    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ready  = cpu_ready_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: environment RAMs and a main-memory responder, plus a
// transaction-level cache model that predicts data, latency, counters and side effects.
module tb_cache_controller;

    localparam int IW = 3;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int TW = AW - IW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_ready;
    logic [IW-1:0] tag_index, data_index;
    logic [TW-1:0] tag_wdata, tag_rdata;
    logic          tag_write, tag_read, data_write, data_read;
    logic [DW-1:0] data_wdata, data_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   hit_count, miss_count;
    logic [2:0]    dbg_state;

    cache_controller #(.index(IW), .memorybits(AW), .databits(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .tag_index(tag_index), .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
        .tag_write(tag_write), .tag_read(tag_read),
        .data_index(data_index), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_write(data_write), .data_read(data_read),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Tag and data RAMs with registered, one-cycle read latency.
    logic [TW-1:0] tag_ram  [8];
    logic [DW-1:0] data_ram [8];
    always @(posedge clk) begin
        if (tag_read)   tag_rdata <= tag_ram[tag_index];
        if (tag_write)  tag_ram[tag_index] <= tag_wdata;
        if (data_read)  data_rdata <= data_ram[data_index];
        if (data_write) data_ram[data_index] <= data_wdata;
    end

    // Main memory: acks after ack_delay extra cycles of mem_req, one-cycle ack.
    logic [DW-1:0] sim_mem [32];
    int            ack_delay = 0;
    int            req_cycles;
    int            n_mem_rd = 0;
    int            n_mem_wr = 0;
    logic [AW-1:0] last_mem_addr = '0;
    logic [DW-1:0] last_mem_wdata = '0;

    initial begin
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        req_cycles = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack    = 1'b0;
                req_cycles = 0;
            end else if (mem_req) begin
                req_cycles++;
                if (req_cycles > ack_delay) begin
                    mem_ack       = 1'b1;
                    last_mem_addr = mem_addr;
                    if (mem_we) begin
                        n_mem_wr++;
                        last_mem_wdata    = mem_wdata;
                        sim_mem[mem_addr] = mem_wdata;
                    end else begin
                        n_mem_rd++;
                        mem_rdata = sim_mem[mem_addr];
                    end
                end
            end else begin
                req_cycles = 0;
            end
        end
    end

    // Behavioural model: cache lines, reference memory, counters.
    bit            m_valid [8];
    logic [TW-1:0] m_tag   [8];
    logic [DW-1:0] m_data  [8];
    logic [DW-1:0] ref_mem [32];
    logic [15:0]   m_hits, m_misses;
    logic [DW-1:0] exp_q [$];

    int            n_checks = 0;
    int            n_pass = 0;
    logic [DW-1:0] last_rdata;
    int            last_lat;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_hits   = '0;
        m_misses = '0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Issue one request starting at a negedge; return at the negedge in the cpu_ready cycle.
    task automatic do_req(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int delay);
        logic [IW-1:0] idx;
        logic [TW-1:0] tg;
        bit            exp_hit, seen, idx_ok;
        int            exp_lat, exp_memcyc, exp_twr, exp_dwr;
        int            n, req_cyc, twr, dwr, rd0, wr0;
        logic [DW-1:0] exp_rdata;

        idx     = addr[IW-1:0];
        tg      = addr[AW-1:IW];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        if (!we) begin
            if (exp_hit) begin
                exp_rdata = m_data[idx];
                exp_lat = 3; exp_memcyc = 0; exp_twr = 0; exp_dwr = 0;
                m_hits++;
            end else begin
                exp_rdata = ref_mem[addr];
                exp_lat = delay + 5; exp_memcyc = delay + 1; exp_twr = 1; exp_dwr = 1;
                m_misses++;
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = ref_mem[addr];
            end
            exp_q.push_back(exp_rdata);
        end else begin
            exp_lat = delay + 4; exp_memcyc = delay + 1; exp_twr = 0;
            exp_dwr = exp_hit ? 1 : 0;
            if (exp_hit) begin
                m_hits++;
                m_data[idx] = wdata;
            end else begin
                m_misses++;
            end
            ref_mem[addr] = wdata;
        end

        ack_delay = delay;
        rd0 = n_mem_rd;
        wr0 = n_mem_wr;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        n = 0; req_cyc = 0; twr = 0; dwr = 0; seen = 1'b0; idx_ok = 1'b1;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (mem_req) req_cyc++;
            if (tag_write) twr++;
            if (data_write) begin
                dwr++;
                if (data_index != idx) idx_ok = 1'b0;
            end
            if (cpu_ready) seen = 1'b1;
            else begin
                // Junk requests while busy must be ignored.
                cpu_req   = ($urandom_range(0, 3) == 0);
                cpu_we    = 1'($urandom);
                cpu_addr  = AW'($urandom);
                cpu_wdata = DW'($urandom);
            end
        end
        cpu_req  = 1'b0;
        last_lat = n;

        chk("ready_seen", 32'(seen), 1);
        chk("latency", n, exp_lat);
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
        chk("mem_req_cycles", req_cyc, exp_memcyc);
        chk("mem_reads", n_mem_rd - rd0, 32'(!we && !exp_hit));
        chk("mem_writes", n_mem_wr - wr0, 32'(we));
        chk("tag_writes", twr, exp_twr);
        chk("data_writes", dwr, exp_dwr);
        chk("data_index", 32'(idx_ok), 1);
        if (exp_memcyc != 0) chk("mem_addr", last_mem_addr, addr);
        if (we) chk("mem_wdata", last_mem_wdata, wdata);
        if (!we) begin
            last_rdata = cpu_rdata;
            if (exp_q.size() == 0) chk("exp_q_nonempty", 0, 1);
            else chk("cpu_rdata", cpu_rdata, exp_q.pop_front());
        end
    endtask

    int  t;
    bit  any_ready, any_req;

    initial begin
        for (int i = 0; i < 32; i++) begin
            sim_mem[i] = DW'($urandom);
            ref_mem[i] = sim_mem[i];
        end
        sim_mem[5'h0B] = 8'hA5; ref_mem[5'h0B] = 8'hA5;
        sim_mem[5'h1B] = 8'h5A; ref_mem[5'h1B] = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            tag_ram[i]  = '0;
            data_ram[i] = '0;
        end
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        @(negedge clk);
        do_reset();

        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_strobes", {tag_read, tag_write, data_read, data_write}, 0);

        // Cold read miss, then hit.
        do_req(1'b0, 5'b01011, 8'h00, 2);
        chk("lit_cold_rdata", last_rdata, 8'hA5);
        chk("lit_cold_miss", miss_count, 1);
        chk("lit_cold_addr", last_mem_addr, 5'h0B);
        chk("lit_cold_lat", last_lat, 7);
        do_req(1'b0, 5'b01011, 8'h00, 2);
        chk("lit_hit_lat", last_lat, 3);
        chk("lit_hit_rdata", last_rdata, 8'hA5);
        chk("lit_hit_count", hit_count, 1);

        // Conflict eviction on index 3.
        @(negedge clk);
        do_req(1'b0, 5'b11011, 8'h00, 1);
        chk("lit_evict_rdata", last_rdata, 8'h5A);
        do_req(1'b0, 5'b01011, 8'h00, 3);
        chk("lit_evict_miss", miss_count, 3);
        chk("lit_evict_rdata2", last_rdata, 8'hA5);

        // Write hit, then read back.
        do_req(1'b1, 5'b01011, 8'h3C, 2);
        chk("lit_wh_hit", hit_count, 2);
        chk("lit_wh_wdata", last_mem_wdata, 8'h3C);
        do_req(1'b0, 5'b01011, 8'h00, 0);
        chk("lit_wh_read", last_rdata, 8'h3C);

        // Write miss leaves the cache alone; the following read misses.
        do_req(1'b1, 5'b00100, 8'h77, 1);
        do_req(1'b0, 5'b00100, 8'h00, 1);
        chk("lit_wm_miss", miss_count, 5);
        chk("lit_wm_rdata", last_rdata, 8'h77);

        // Back-to-back hits issued in the cpu_ready cycle.
        do_req(1'b0, 5'b01011, 8'h00, 0);
        do_req(1'b0, 5'b00100, 8'h00, 0);
        chk("lit_b2b_lat", last_lat, 3);
        chk("lit_b2b_hits", hit_count, 5);

        // Reset during MEM_READ.
        @(negedge clk);
        ack_delay = 20;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'b10110;
        @(negedge clk);
        cpu_req = 1'b0;
        t = 0;
        while (!mem_req && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("mid_mem_req_up", mem_req, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_mem_req_drop", mem_req, 0);
        chk("mid_no_ready", cpu_ready, 0);
        chk("mid_hit_count", hit_count, 0);
        chk("mid_miss_count", miss_count, 0);
        reset = 1'b0;
        model_reset();
        any_ready = 1'b0; any_req = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (cpu_ready) any_ready = 1'b1;
            if (mem_req) any_req = 1'b1;
        end
        chk("mid_quiet_ready", 32'(any_ready), 0);
        chk("mid_quiet_req", 32'(any_req), 0);
        do_req(1'b0, 5'b01011, 8'h00, 1);
        chk("lit_post_rst_miss", miss_count, 1);
        chk("lit_post_rst_rdata", last_rdata, 8'h3C);

        // Randomized traffic.
        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req(1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15)),
                   DW'($urandom), $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for the direct-mapped cache: it owns the tag RAM and the cache data RAM and interfaces to main memory. It accepts single CPU read/write requests, performs tag lookup, and on a read miss fetches the word from main memory and refills tag and data. The cache is write-through with no write-allocate. The tag RAM carries no valid bits, so this block holds the per-line valid bits and clears them on reset.

## Interface
- index, 3, index field width; number of lines = 2^index
- memorybits, 5, CPU/main-memory address width; tag width = memorybits-index
- databits, 8, data word width

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  memorybits  address; bits [index-1:0] are the index, upper bits are the tag
- cpu_wdata  in  databits  write data
- cpu_rdata  out  databits  read data; valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- tag_index  out  index  tag RAM address
- tag_wdata  out  memorybits-index  tag to write
- tag_rdata  in  memorybits-index  tag RAM output; registered, 1-cycle read latency
- tag_write, tag_read  out  1  tag RAM strobes
- data_index  out  index  data RAM address
- data_wdata  out  databits
- data_rdata  in  databits  registered, 1-cycle read latency
- data_write, data_read  out  1
- mem_req  out  1  main memory request; held until ack
- mem_we  out  1  main memory write
- mem_addr  out  memorybits
- mem_wdata  out  databits
- mem_rdata  in  databits  valid in the mem_ack cycle
- mem_ack  in  1  one-cycle acknowledge
- hit_count, miss_count  out  16  wrapping event counters

## Operation
- Request latch: in IDLE, cpu_req=1 latches cpu_we, cpu_addr, and cpu_wdata into internal registers. All later outputs derive from this latched copy.
- IDLE: if cpu_req=1, go to LOOKUP.
- LOOKUP: tag_read=1 and data_read=1 at the latched index. Go to COMPARE.
- COMPARE: hit = valid[index] && tag_rdata == latched tag.
  - Read hit: cpu_rdata <= data_rdata, cpu_ready <= 1, hit_count++, go to IDLE.
  - Read miss: miss_count++, go to MEM_READ.
  - Write hit: data_write=1 with cpu_wdata at the index, hit_count++, go to MEM_WRITE.
  - Write miss: miss_count++, go to MEM_WRITE. The cache is not modified.
- MEM_READ: mem_req=1, mem_we=0, mem_addr=latched address. When mem_ack=1, capture mem_rdata and go to FILL.
- FILL: tag_write=1 with the latched tag, data_write=1 with the captured word, valid[index] <= 1, cpu_rdata <= captured word, cpu_ready <= 1. Go to IDLE. A refill overwrites any line at that index (conflict eviction; no writeback needed).
- MEM_WRITE: mem_req=1, mem_we=1, mem_addr and mem_wdata from the latch. When mem_ack=1, cpu_ready <= 1 and go to IDLE.
- RAM and memory strobes are decoded combinationally from state and are 0 in every other state. tag_index and data_index always equal the latched index.
- cpu_req is ignored outside IDLE. mem_ack is ignored outside MEM_READ and MEM_WRITE.
- Counters wrap from 0xFFFF to 0.

## Timing
- Reset values: state IDLE, all valid bits 0, cpu_ready 0, cpu_rdata 0, all strobes 0, mem_req 0, counters 0. Request latch cleared to 0.
- Reset asserted mid-operation aborts the transaction at that edge:
  - mem_req drops in the following cycle.
  - No cpu_ready is issued.
  - A pending FILL is discarded.
- Let E0 be the edge that samples cpu_req.
  - Read hit: cpu_ready is high in the cycle after E2 (3 edges).
  - Read miss: 2 + (edges until mem_ack sampled) + 2.
  - Write: cpu_ready is high the cycle after the edge that samples mem_ack.
- cpu_ready is exactly one cycle wide. That cycle is IDLE, so a new cpu_req presented in it is accepted (back-to-back).
- mem_req stays high continuously until the edge that samples mem_ack=1, then it is 0.

## Test plan
- Cold read miss then hit:
  - After reset, read 5'b01011; memory acks 2 cycles after mem_req with 0xA5. Expect one mem read to addr 0x0B, cpu_rdata=0xA5, miss_count=1.
  - Reread 5'b01011: cpu_ready 3 edges after request, 0xA5, no mem_req, hit_count=1.
- Conflict eviction:
  - Read 5'b11011, memory returns 0x5A: miss, refill of index 3 with tag 2'b11.
  - Then read 5'b01011: miss again, new mem read.
- Write hit: with 0xA5 cached at 5'b01011, write 0x3C. Expect data_write at index 3, mem write addr 0x0B data 0x3C, hit_count++. The next read hits with 0x3C.
- Write miss: write 0x77 to 5'b00100 with the line invalid. Expect a mem write only, no tag_write or data_write; the next read to 5'b00100 misses.
- Reset mid-MEM_READ: assert reset while mem_req=1. Expect mem_req=0 the next cycle, no cpu_ready, counters 0, and the previously cached 5'b01011 now misses.
- Back-to-back: issue a new read in the cpu_ready cycle of a hit. It is accepted, and its cpu_ready follows 3 edges later.
